// File: rtl/vdp_cpu_port_if.sv
// Bus bundle between the Z80 I/O decode, the CPU port and its VRAM/CRAM/register targets.
interface vdp_cpu_port_if #(
    parameter int unsigned VRAM_AW = 14
);
    logic               cpu_wr;
    logic               cpu_rd;
    logic               cpu_port;
    logic [7:0]         cpu_din;
    logic [7:0]         cpu_dout;
    logic               busy;
    logic [VRAM_AW-1:0] vram_a;
    logic [7:0]         vram_wd;
    logic               vram_we;
    logic [7:0]         vram_rd;
    logic [4:0]         cram_a;
    logic [11:0]        cram_wd;
    logic               cram_we;
    logic               reg_we;
    logic [3:0]         reg_addr;
    logic [7:0]         reg_data;
    logic [7:0]         status_in;
    logic               status_clr;

    modport master (
        output cpu_wr, cpu_rd, cpu_port, cpu_din, vram_rd, status_in,
        input  cpu_dout, busy, vram_a, vram_wd, vram_we, cram_a, cram_wd, cram_we,
               reg_we, reg_addr, reg_data, status_clr
    );

    modport slave (
        input  cpu_wr, cpu_rd, cpu_port, cpu_din, vram_rd, status_in,
        output cpu_dout, busy, vram_a, vram_wd, vram_we, cram_a, cram_wd, cram_we,
               reg_we, reg_addr, reg_data, status_clr
    );
endinterface

// File: rtl/vdp_cpu_port.sv
// CPU-side VDP port: decodes data/control accesses into VRAM, CRAM and register writes,
// and keeps a one-byte VRAM read-ahead buffer filled by a small prefetch FSM.
module vdp_cpu_port #(
    parameter int unsigned VRAM_AW = 14,
    parameter bit          GG_MODE = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    vdp_cpu_port_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_F_ADDR = 2'd1;
    localparam logic [1:0] S_F_DATA = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [1:0]         code_q, code_d;
    logic               flag_q, flag_d;
    logic [7:0]         read_buf_q, read_buf_d;
    logic [7:0]         cram_latch_q, cram_latch_d;

    logic [7:0]         dout_q, dout_d;
    logic               busy_q, busy_d;
    logic [VRAM_AW-1:0] vram_a_q, vram_a_d;
    logic [7:0]         vram_wd_q, vram_wd_d;
    logic               vram_we_q, vram_we_d;
    logic [4:0]         cram_a_q, cram_a_d;
    logic [11:0]        cram_wd_q, cram_wd_d;
    logic               cram_we_q, cram_we_d;
    logic               reg_we_q, reg_we_d;
    logic [3:0]         reg_addr_q, reg_addr_d;
    logic [7:0]         reg_data_q, reg_data_d;
    logic               status_clr_q, status_clr_d;

    logic               wr_go;
    logic               rd_go;
    logic               start_pf;
    logic [VRAM_AW-1:0] addr_inc;

    // Write beats read on a simultaneous strobe; everything is ignored while prefetching.
    assign wr_go    = bus.cpu_wr && !busy_q;
    assign rd_go    = bus.cpu_rd && !bus.cpu_wr && !busy_q;
    assign addr_inc = addr_q + VRAM_AW'(1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        code_d       = code_q;
        flag_d       = flag_q;
        read_buf_d   = read_buf_q;
        cram_latch_d = cram_latch_q;
        dout_d       = dout_q;
        busy_d       = busy_q;
        vram_a_d     = vram_a_q;
        vram_wd_d    = vram_wd_q;
        vram_we_d    = 1'b0;
        cram_a_d     = cram_a_q;
        cram_wd_d    = cram_wd_q;
        cram_we_d    = 1'b0;
        reg_we_d     = 1'b0;
        reg_addr_d   = reg_addr_q;
        reg_data_d   = reg_data_q;
        status_clr_d = 1'b0;
        start_pf     = 1'b0;

        if (wr_go) begin
            if (bus.cpu_port) begin
                if (!flag_q) begin
                    addr_d[7:0] = bus.cpu_din;
                    flag_d      = 1'b1;
                end else begin
                    flag_d = 1'b0;
                    code_d = bus.cpu_din[7:6];
                    addr_d = VRAM_AW'({bus.cpu_din[5:0], addr_q[7:0]});
                    case (bus.cpu_din[7:6])
                        2'd0: start_pf = 1'b1;
                        2'd2: begin
                            reg_we_d   = 1'b1;
                            reg_addr_d = bus.cpu_din[3:0];
                            reg_data_d = addr_q[7:0];
                        end
                        default: ;
                    endcase
                end
            end else begin
                flag_d = 1'b0;
                addr_d = addr_inc;
                if (code_q != 2'd3) begin
                    vram_we_d  = 1'b1;
                    vram_a_d   = addr_q;
                    vram_wd_d  = bus.cpu_din;
                    read_buf_d = bus.cpu_din;
                end else if (GG_MODE) begin
                    // Game Gear CRAM: even byte is latched, odd byte commits the 12-bit entry.
                    if (!addr_q[0]) begin
                        cram_latch_d = bus.cpu_din;
                    end else begin
                        cram_we_d = 1'b1;
                        cram_a_d  = addr_q[5:1];
                        cram_wd_d = {bus.cpu_din[3:0], cram_latch_q};
                    end
                end else begin
                    cram_we_d = 1'b1;
                    cram_a_d  = addr_q[4:0];
                    cram_wd_d = {6'b0, bus.cpu_din[5:0]};
                end
            end
        end else if (rd_go) begin
            flag_d = 1'b0;
            if (bus.cpu_port) begin
                dout_d       = bus.status_in;
                status_clr_d = 1'b1;
            end else begin
                dout_d   = read_buf_q;
                start_pf = 1'b1;
            end
        end

        // Prefetch: present address, let the RAM sample it, then capture the byte.
        case (state_q)
            S_IDLE: begin
                if (start_pf) begin
                    state_d  = S_F_ADDR;
                    vram_a_d = addr_d;
                    busy_d   = 1'b1;
                end
            end
            S_F_ADDR: state_d = S_F_DATA;
            S_F_DATA: begin
                state_d    = S_IDLE;
                read_buf_d = bus.vram_rd;
                addr_d     = addr_inc;
                busy_d     = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            code_q       <= 2'd0;
            flag_q       <= 1'b0;
            read_buf_q   <= 8'd0;
            cram_latch_q <= 8'd0;
            dout_q       <= 8'd0;
            busy_q       <= 1'b0;
            vram_a_q     <= '0;
            vram_wd_q    <= 8'd0;
            vram_we_q    <= 1'b0;
            cram_a_q     <= 5'd0;
            cram_wd_q    <= 12'd0;
            cram_we_q    <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= 4'd0;
            reg_data_q   <= 8'd0;
            status_clr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            code_q       <= code_d;
            flag_q       <= flag_d;
            read_buf_q   <= read_buf_d;
            cram_latch_q <= cram_latch_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            vram_a_q     <= vram_a_d;
            vram_wd_q    <= vram_wd_d;
            vram_we_q    <= vram_we_d;
            cram_a_q     <= cram_a_d;
            cram_wd_q    <= cram_wd_d;
            cram_we_q    <= cram_we_d;
            reg_we_q     <= reg_we_d;
            reg_addr_q   <= reg_addr_d;
            reg_data_q   <= reg_data_d;
            status_clr_q <= status_clr_d;
        end
    end

    assign bus.cpu_dout   = dout_q;
    assign bus.busy       = busy_q;
    assign bus.vram_a     = vram_a_q;
    assign bus.vram_wd    = vram_wd_q;
    assign bus.vram_we    = vram_we_q;
    assign bus.cram_a     = cram_a_q;
    assign bus.cram_wd    = cram_wd_q;
    assign bus.cram_we    = cram_we_q;
    assign bus.reg_we     = reg_we_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_data   = reg_data_q;
    assign bus.status_clr = status_clr_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed vector bench for vdp_cpu_port with a synchronous VRAM model behind it.
module tb_vdp_cpu_port;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vdp_cpu_port_if #(.VRAM_AW(14)) bus ();
    vdp_cpu_port #(.VRAM_AW(14), .GG_MODE(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [0:16383];
    always @(posedge clk) begin
        if (bus.vram_we) mem[bus.vram_a] <= bus.vram_wd;
        bus.vram_rd <= mem[bus.vram_a];
    end

    typedef struct {
        string       name;
        logic        wr, rd, port;
        logic [7:0]  din;
        int          gap;
        logic        vwe;  logic [13:0] va;  logic [7:0]  vwd;
        logic        cwe;  logic [4:0]  ca;  logic [11:0] cwd;
        logic        rwe;  logic [3:0]  ra;  logic [7:0]  rdat;
        logic        sclr; logic        busy; logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(string nm, logic wr, logic rd, logic port, logic [7:0] din, int gap,
                                logic vwe, logic [13:0] va, logic [7:0] vwd,
                                logic cwe, logic [4:0] ca, logic [11:0] cwd,
                                logic rwe, logic [3:0] ra, logic [7:0] rdat,
                                logic sclr, logic busy, logic [7:0] dout);
        vec_t v;
        v.name = nm; v.wr = wr; v.rd = rd; v.port = port; v.din = din; v.gap = gap;
        v.vwe = vwe; v.va = va; v.vwd = vwd; v.cwe = cwe; v.ca = ca; v.cwd = cwd;
        v.rwe = rwe; v.ra = ra; v.rdat = rdat; v.sclr = sclr; v.busy = busy; v.dout = dout;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the strobe edge.
    task automatic strobe(input logic wr, input logic rd, input logic port, input logic [7:0] d);
        bus.cpu_wr   = wr;
        bus.cpu_rd   = rd;
        bus.cpu_port = port;
        bus.cpu_din  = d;
        @(posedge clk);
        #1;
        bus.cpu_wr = 1'b0;
        bus.cpu_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        strobe(v.wr, v.rd, v.port, v.din);
        chk({v.name, ".vram_we"}, 32'(bus.vram_we), 32'(v.vwe));
        chk({v.name, ".cram_we"}, 32'(bus.cram_we), 32'(v.cwe));
        chk({v.name, ".reg_we"}, 32'(bus.reg_we), 32'(v.rwe));
        chk({v.name, ".status_clr"}, 32'(bus.status_clr), 32'(v.sclr));
        chk({v.name, ".busy"}, 32'(bus.busy), 32'(v.busy));
        chk({v.name, ".cpu_dout"}, 32'(bus.cpu_dout), 32'(v.dout));
        if (v.vwe || v.busy) chk({v.name, ".vram_a"}, 32'(bus.vram_a), 32'(v.va));
        if (v.vwe) chk({v.name, ".vram_wd"}, 32'(bus.vram_wd), 32'(v.vwd));
        if (v.cwe) chk({v.name, ".cram"}, {15'd0, bus.cram_a, bus.cram_wd}, {15'd0, v.ca, v.cwd});
        if (v.rwe) chk({v.name, ".reg"}, {20'd0, bus.reg_addr, bus.reg_data}, {20'd0, v.ra, v.rdat});
        @(negedge clk);
        chk({v.name, ".pulse_clear"},
            32'({bus.vram_we, bus.cram_we, bus.reg_we, bus.status_clr}), 32'd0);
        repeat (v.gap) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h1234] = 8'h11;
        mem[14'h1235] = 8'h22;

        bus.cpu_wr    = 1'b0;
        bus.cpu_rd    = 1'b0;
        bus.cpu_port  = 1'b0;
        bus.cpu_din   = 8'h00;
        bus.status_in = 8'hC3;
        rst = 1'b1;

        //          name           wr   rd   port din   gap vwe  va       vwd    cwe  ca    cwd      rwe  ra    rdat   sclr busy dout
        vecs.push_back(mk("reg_lo",     1, 0, 1, 8'h0F, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk("reg_hi",     1, 0, 1, 8'h82, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 1, 4'd2, 8'h0F, 0, 0, 8'h00));
        vecs.push_back(mk("fill_lo",    1, 0, 1, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk("fill_hi",    1, 0, 1, 8'h40, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk("fill_aa",    1, 0, 0, 8'hAA, 0, 1, 14'h0000, 8'hAA, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk("fill_55",    1, 0, 0, 8'h55, 0, 1, 14'h0001, 8'h55, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk("fill_rd",    0, 1, 0, 8'h00, 1, 0, 14'h0002, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 1, 8'h55));
        vecs.push_back(mk("ra_lo",      1, 0, 1, 8'h34, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h55));
        vecs.push_back(mk("ra_hi",      1, 0, 1, 8'h12, 1, 0, 14'h1234, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 1, 8'h55));
        vecs.push_back(mk("ra_rd1",     0, 1, 0, 8'h00, 1, 0, 14'h1235, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 1, 8'h11));
        vecs.push_back(mk("ra_rd2",     0, 1, 0, 8'h00, 1, 0, 14'h1236, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 1, 8'h22));
        vecs.push_back(mk("ra_addr",    1, 0, 0, 8'h77, 0, 1, 14'h1237, 8'h77, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h22));
        vecs.push_back(mk("gg_lo",      1, 0, 1, 8'h02, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h22));
        vecs.push_back(mk("gg_hi",      1, 0, 1, 8'hC0, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h22));
        vecs.push_back(mk("gg_even",    1, 0, 0, 8'hBC, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h22));
        vecs.push_back(mk("gg_odd",     1, 0, 0, 8'h0A, 0, 0, 14'h0000, 8'h00, 1, 5'd1, 12'hABC, 0, 4'd0, 8'h00, 0, 0, 8'h22));
        vecs.push_back(mk("st_lo",      1, 0, 1, 8'h34, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'h22));
        vecs.push_back(mk("st_rd",      0, 1, 1, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 1, 0, 8'hC3));
        vecs.push_back(mk("st_first",   1, 0, 1, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'hC3));
        vecs.push_back(mk("st_second",  1, 0, 1, 8'h81, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 1, 4'd1, 8'h00, 0, 0, 8'hC3));
        vecs.push_back(mk("wrap_lo",    1, 0, 1, 8'hFF, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'hC3));
        vecs.push_back(mk("wrap_hi",    1, 0, 1, 8'h7F, 0, 0, 14'h0000, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'hC3));
        vecs.push_back(mk("wrap_wr_rd", 1, 1, 0, 8'h99, 0, 1, 14'h3FFF, 8'h99, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'hC3));
        vecs.push_back(mk("wrap_next",  1, 0, 0, 8'h66, 0, 1, 14'h0000, 8'h66, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 0, 8'hC3));
        vecs.push_back(mk("wrap_rd",    0, 1, 0, 8'h00, 1, 0, 14'h0001, 8'h00, 0, 5'd0, 12'h000, 0, 4'd0, 8'h00, 0, 1, 8'h66));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.enables", 32'({bus.vram_we, bus.cram_we, bus.reg_we, bus.status_clr, bus.busy}), 32'd0);
        chk("reset.vram", {10'd0, bus.vram_a, bus.vram_wd}, 32'd0);
        chk("reset.cram_reg", {3'd0, bus.cram_a, bus.cram_wd, bus.reg_addr, bus.reg_data}, 32'd0);
        chk("reset.dout", 32'(bus.cpu_dout), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Strobes landing while a prefetch is in flight must be dropped.
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        chk("busy.start", {17'd0, bus.busy, bus.vram_a}, {17'd0, 1'b1, 14'h0000});
        strobe(1'b1, 1'b0, 1'b0, 8'hEE);
        chk("busy.wr_ignored", 32'({bus.busy, bus.vram_we}), 32'b10);
        strobe(1'b0, 1'b1, 1'b0, 8'h00);
        chk("busy.rd_ignored", {22'd0, bus.busy, bus.vram_we, bus.cpu_dout}, {22'd0, 1'b0, 1'b0, 8'h66});
        strobe(1'b1, 1'b0, 1'b0, 8'h12);
        chk("busy.after", {9'd0, bus.vram_we, bus.vram_a, bus.vram_wd}, {9'd0, 1'b1, 14'h0001, 8'h12});

        // Reset while the prefetch sits in F_DATA.
        strobe(1'b1, 1'b0, 1'b1, 8'h34);
        strobe(1'b1, 1'b0, 1'b1, 8'h12);
        chk("rstpf.busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstpf.cleared", {9'd0, bus.busy, bus.vram_a, bus.cpu_dout}, 32'd0);
        rst = 1'b0;
        strobe(1'b0, 1'b1, 1'b0, 8'h00);
        chk("rstpf.read_buf", {9'd0, bus.busy, bus.vram_a, bus.cpu_dout}, {9'd0, 1'b1, 14'h0000, 8'h00});
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- CPU-side VDP port. It decodes Z80 data/control port accesses and writes VRAM, CRAM and VDP registers.
- It also services VRAM reads through a one-byte read-ahead buffer.
- It is the writer/producer for the VRAM that the background and sprite renderers read.
- It sits between the Z80 I/O decode and the VRAM write port, the CRAM and the register file.

Parameters:
- VRAM_AW, 14, VRAM address width; the address register wraps modulo 2^VRAM_AW.
- GG_MODE, 1, 1 = Game Gear 12-bit CRAM via even/odd byte latch; 0 = SMS 6-bit CRAM.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_wr  in  1  one-cycle write strobe
- cpu_rd  in  1  one-cycle read strobe
- cpu_port  in  1  0 = data port, 1 = control port
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data, registered, held until next read
- busy  out  1  high while a VRAM prefetch is in flight
- vram_a  out  VRAM_AW  VRAM address (write or prefetch read)
- vram_wd  out  8  VRAM write data
- vram_we  out  1  one-cycle VRAM write enable
- vram_rd  in  8  VRAM read data, valid one cycle after vram_a is registered
- cram_a  out  5  CRAM entry index
- cram_wd  out  12  CRAM entry data
- cram_we  out  1  one-cycle CRAM write enable
- reg_we  out  1  one-cycle register write enable
- reg_addr  out  4  register index
- reg_data  out  8  register value
- status_in  in  8  VDP status byte
- status_clr  out  1  one-cycle pulse on status read

Behaviour:
- Reset (synchronous): all outputs 0; addr = 0; code = 0; second-byte flag = 0; read_buf = 0; cram_latch = 0; FSM = IDLE.
- State: addr[VRAM_AW-1:0], code[1:0], flag, read_buf[7:0], cram_latch[7:0].
- Strobe arbitration: cpu_wr and cpu_rd together -> write wins, read dropped. Strobes while busy = 1 are ignored with no state change. All write-enable and pulse outputs are 0 except on the single cycle they fire.
- Control write, flag = 0: addr[7:0] <= din; flag <= 1.
- Control write, flag = 1: code <= din[7:6]; addr[13:8] <= din[5:0]; flag <= 0. Then by code:
  - code 0: start prefetch.
  - code 2: next cycle reg_we = 1, reg_addr = din[3:0], reg_data = addr[7:0] (the first byte).
  - codes 1 and 3: no further action.
- Data write (flag <= 0), code != 3: next cycle vram_we = 1, vram_a = addr, vram_wd = din. read_buf <= din; addr <= addr + 1 (wraps).
- Data write, code = 3, GG_MODE = 1:
  - addr[0] = 0: cram_latch <= din, no cram_we.
  - addr[0] = 1: next cycle cram_we = 1, cram_a = addr[5:1], cram_wd = {din[3:0], cram_latch}.
  - addr increments in both cases.
- Data write, code = 3, GG_MODE = 0: cram_we = 1, cram_a = addr[4:0], cram_wd = {6'b0, din[5:0]}; addr increments.
- Data read: cpu_dout <= read_buf on the strobe edge; flag <= 0; start prefetch.
- Control read: cpu_dout <= status_in; status_clr pulses next cycle; flag <= 0.
- Prefetch FSM:
  - IDLE -> F_ADDR: vram_a <= addr, busy = 1.
  - F_ADDR -> F_DATA: RAM samples address.
  - F_DATA -> IDLE: read_buf <= vram_rd; addr <= addr + 1; busy <= 0.
  - busy is high for exactly 2 cycles after the triggering strobe.
- Address wrap: addr = 14'h3FFF + 1 -> 14'h0000, for writes and prefetch alike.
- Reset mid-prefetch: FSM returns to IDLE, read_buf = 0, busy = 0 on the next cycle.

Test Plan:
- Register write: control 8'h0F then 8'h82 -> one reg_we pulse, reg_addr = 2, reg_data = 8'h0F; flag cleared; no vram_we.
- VRAM fill: control 8'h00, 8'h40 (code 1, addr 0) then data 8'hAA, 8'h55 -> vram_we at addr 0 (AA) and addr 1 (55); a following data read returns 8'h55 (read_buf from the last write).
- Read-ahead: VRAM[0x1234] = 8'h11, VRAM[0x1235] = 8'h22; control 8'h34, 8'h12 (code 0) -> busy for 2 cycles; first data read returns 8'h11, second returns 8'h22; addr ends at 0x1237.
- GG CRAM: control 8'h02, 8'hC0 (code 3, addr 2); data 8'hBC then 8'h0A -> single cram_we, cram_a = 1, cram_wd = 12'hABC.
- Flag reset: control 8'h34 then status read -> cpu_dout = status_in, status_clr pulse; next control byte 8'h00 is treated as a first byte (flag = 1, no code change).
- Edge cases:
  - addr 0x3FFF data write -> addr becomes 0x0000.
  - Strobe during busy -> ignored.
  - Simultaneous cpu_wr and cpu_rd -> only the write takes effect.
  - rst asserted in F_DATA -> busy = 0, read_buf = 0.
